// File: rtl/rv32i_types.sv
// Shared RV32I decode types: raw instruction views, immediate formats and the
// decoded packet that travels through the decode queue.
package rv32i_types;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_VARIANT = 7'b0100000;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   typedef enum logic [2:0] {
      fmt_r,
      fmt_i,
      fmt_s,
      fmt_b,
      fmt_u,
      fmt_j
   } imm_fmt_t;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } r_type_t;

   typedef struct packed {
      logic [11:0] imm11_0;
      logic [4:0]  rs1;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [6:0]  opcode;
   } i_type_t;

   typedef struct packed {
      logic [6:0] imm11_5;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] imm4_0;
      logic [6:0] opcode;
   } s_type_t;

   // Branch immediate bits are scattered: bit 12 at the top, bit 11 at instr[7]
   typedef struct packed {
      logic       imm12;
      logic [5:0] imm10_5;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [3:0] imm4_1;
      logic       imm11;
      logic [6:0] opcode;
   } b_type_t;

   typedef struct packed {
      logic [19:0] imm31_12;
      logic [4:0]  rd;
      logic [6:0]  opcode;
   } u_type_t;

   typedef struct packed {
      logic       imm20;
      logic [9:0] imm10_1;
      logic       imm11;
      logic [7:0] imm19_12;
      logic [4:0] rd;
      logic [6:0] opcode;
   } j_type_t;

   typedef union packed {
      logic [31:0] raw;
      r_type_t     r;
      i_type_t     i;
      s_type_t     s;
      b_type_t     b;
      u_type_t     u;
      j_type_t     j;
   } instr_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        illegal;
      logic [31:0] pc;
   } decode_pkt_t;

endpackage

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I field extraction, immediate assembly and
// legality check; the PC is attached by the queue, so pc is left zero here.
module rv32i_decoder
   import rv32i_types::*;
(
   input  instr_t      instr,
   output decode_pkt_t pkt
);

   imm_fmt_t    fmt;
   logic        illegal;
   logic [31:0] imm;
   logic [2:0]  f3;
   logic [6:0]  f7;

   assign f3 = instr.r.funct3;
   assign f7 = instr.r.funct7;

   always_comb begin
      fmt     = fmt_r;
      illegal = 1'b0;
      case (instr.r.opcode)
         OP_LOAD: begin
            fmt     = fmt_i;
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OP_STORE: begin
            fmt     = fmt_s;
            illegal = (f3 > 3'b010);
         end
         OP_BRANCH: begin
            fmt     = fmt_b;
            illegal = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OP_JALR: begin
            fmt     = fmt_i;
            illegal = (f3 != 3'b000);
         end
         OP_JAL:   fmt = fmt_j;
         OP_LUI:   fmt = fmt_u;
         OP_AUIPC: fmt = fmt_u;
         // Shift-immediates reuse funct7 as an encoding qualifier
         OP_IMM: begin
            fmt = fmt_i;
            if (f3 == F3_SLL) begin
               illegal = (f7 != F7_BASE);
            end else if (f3 == F3_SR) begin
               illegal = (f7 != F7_BASE) && (f7 != F7_VARIANT);
            end
         end
         OP_REG: begin
            fmt = fmt_r;
            if (f7 == F7_VARIANT) begin
               illegal = (f3 != F3_ADD) && (f3 != F3_SR);
            end else begin
               illegal = (f7 != F7_BASE);
            end
         end
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      imm = '0;
      case (fmt)
         fmt_i: imm = {{20{instr.i.imm11_0[11]}}, instr.i.imm11_0};
         fmt_s: imm = {{20{instr.s.imm11_5[6]}}, instr.s.imm11_5, instr.s.imm4_0};
         fmt_b: imm = {{20{instr.b.imm12}}, instr.b.imm11, instr.b.imm10_5,
                       instr.b.imm4_1, 1'b0};
         fmt_u: imm = {instr.u.imm31_12, 12'b0};
         fmt_j: imm = {{12{instr.j.imm20}}, instr.j.imm19_12, instr.j.imm11,
                       instr.j.imm10_1, 1'b0};
         default: imm = '0;
      endcase
      if (illegal) begin
         imm = '0;
      end
   end

   always_comb begin
      pkt         = '0;
      pkt.opcode  = instr.r.opcode;
      pkt.funct3  = f3;
      pkt.funct7  = f7;
      pkt.rd      = instr.r.rd;
      pkt.rs1     = instr.r.rs1;
      pkt.rs2     = instr.r.rs2;
      pkt.imm     = imm;
      pkt.illegal = illegal;
   end

endmodule

// File: rtl/rv32i_decode_queue.sv
// Decode-then-queue stage: instructions are decoded as they arrive and the
// resulting packets are held in a small circular FIFO until consumed.
module rv32i_decode_queue
   import rv32i_types::*;
#(
   parameter int DEPTH    = 4,
   parameter int PC_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [PC_WIDTH-1:0] in_pc,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output decode_pkt_t         out_pkt
);

   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

   decode_pkt_t   mem [DEPTH];
   decode_pkt_t   dec_pkt;
   decode_pkt_t   new_entry;
   instr_t        instr_view;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   assign instr_view = instr_t'(in_instr);

   rv32i_decoder u_decoder (
      .instr (instr_view),
      .pkt   (dec_pkt)
   );

   // in_ready looks only at occupancy, so a full queue never passes through
   assign in_ready  = !rst && (count < DEPTH_CNT);
   assign out_valid = (count != '0);
   assign out_pkt   = out_valid ? mem[rd_ptr] : '0;

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   always_comb begin
      new_entry    = dec_pkt;
      new_entry.pc = 32'(in_pc);
   end

   // Storage is not reset; occupancy alone decides what is visible
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= new_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_decode_queue.sv
// Directed and randomized bench for rv32i_decode_queue, checked against a
// scoreboard queue and an arithmetic instruction-decode reference.
module tb_rv32i_decode_queue;
   import rv32i_types::*;

   localparam int DEPTH    = 4;
   localparam int PC_WIDTH = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         in_instr;
   logic [PC_WIDTH-1:0] in_pc;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   decode_pkt_t         out_pkt;

   int          checks = 0;
   int          passed = 0;
   int          fails  = 0;
   decode_pkt_t model_q [$];

   always #5 clk = ~clk;

   rv32i_decode_queue #(
      .DEPTH    (DEPTH),
      .PC_WIDTH (PC_WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pkt   (out_pkt)
   );

   // Reference decode built from signed arithmetic on the whole word
   function automatic decode_pkt_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
      decode_pkt_t p;
      int          s;
      int          hi;
      int          val;
      bit          ok;
      logic [2:0]  f3;
      logic [6:0]  f7;
      s   = int'(w);
      f3  = w[14:12];
      f7  = w[31:25];
      ok  = 1'b1;
      val = 0;
      case (w[6:0])
         7'h03: begin ok = !(f3 inside {3'd3, 3'd6, 3'd7}); val = s >>> 20; end
         7'h23: begin ok = (f3 <= 3'd2); hi = s >>> 25; val = hi * 32 + int'(w[11:7]); end
         7'h63: begin
            ok  = !(f3 inside {3'd2, 3'd3});
            hi  = s >>> 31;
            val = hi * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
         end
         7'h67: begin ok = (f3 == 3'd0); val = s >>> 20; end
         7'h6F: begin
            hi  = s >>> 31;
            val = hi * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
         end
         7'h13: begin
            if (f3 == 3'd1)      ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            val = s >>> 20;
         end
         7'h33: ok = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5}));
         7'h37, 7'h17: val = s & 32'hFFFF_F000;
         default: ok = 1'b0;
      endcase
      p         = '0;
      p.opcode  = w[6:0];
      p.funct3  = f3;
      p.funct7  = f7;
      p.rd      = w[11:7];
      p.rs1     = w[19:15];
      p.rs2     = w[24:20];
      p.imm     = ok ? 32'(val) : 32'h0;
      p.illegal = !ok;
      p.pc      = pc;
      return p;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [11];
      logic [31:0] w;
      ops = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h13, 7'h33, 7'h37, 7'h17, 7'h7F, 7'h73};
      w      = $urandom;
      w[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
         0:       w[31:25] = 7'h00;
         1:       w[31:25] = 7'h20;
         default: ;
      endcase
      return w;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock of stimulus: compare against the scoreboard, then advance both
   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                input logic ordy, input logic fl, input logic r);
      decode_pkt_t exp_pkt;
      bit          do_push;
      bit          do_pop;
      in_valid  = v;
      in_instr  = instr;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      #1;
      exp_pkt = (model_q.size() != 0) ? model_q[0] : '0;
      checkOutput("in_ready", 128'(in_ready), 128'(!r && (model_q.size() < DEPTH)));
      checkOutput("out_valid", 128'(out_valid), 128'(model_q.size() != 0));
      checkOutput("out_pkt", 128'(out_pkt), 128'(exp_pkt));
      do_push = v && !r && (model_q.size() < DEPTH);
      do_pop  = (model_q.size() != 0) && ordy;
      @(posedge clk);
      if (r || fl) begin
         model_q.delete();
      end else begin
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(ref_decode(instr, pc));
      end
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      applyStimulus(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h0000_0013, 32'h0, 1'b1, 1'b0, 1'b1);

      applyStimulus(1'b1, 32'hFFF0_0093, 32'h100, 1'b0, 1'b0, 1'b0);
      checkOutput("addi_valid", 128'(out_valid), 128'(1));
      checkOutput("addi_rd", 128'(out_pkt.rd), 128'(1));
      checkOutput("addi_rs1", 128'(out_pkt.rs1), 128'(0));
      checkOutput("addi_imm", 128'(out_pkt.imm), 128'(32'hFFFF_FFFF));
      checkOutput("addi_illegal", 128'(out_pkt.illegal), 128'(0));
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      applyStimulus(1'b1, 32'hFE00_0EE3, 32'h104, 1'b0, 1'b0, 1'b0);
      checkOutput("beq_imm", 128'(out_pkt.imm), 128'(32'hFFFF_FFFC));
      applyStimulus(1'b1, 32'h0010_00EF, 32'h108, 1'b1, 1'b0, 1'b0);
      checkOutput("jal_imm", 128'(out_pkt.imm), 128'(32'h0000_0800));
      checkOutput("jal_rd", 128'(out_pkt.rd), 128'(1));
      checkOutput("jal_pc", 128'(out_pkt.pc), 128'(32'h108));
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, rand_instr(), 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      end
      checkOutput("full_in_ready", 128'(in_ready), 128'(0));
      applyStimulus(1'b1, rand_instr(), 32'h210, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("after_pop_in_ready", 128'(in_ready), 128'(1));

      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, rand_instr(), 32'h300 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      end
      checkOutput("stream_head_pc", 128'(out_pkt.pc), 128'(32'h324));
      repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      applyStimulus(1'b1, 32'h0000_007F, 32'h400, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h4000_1033, 32'h404, 1'b0, 1'b0, 1'b0);
      checkOutput("ill0_illegal", 128'(out_pkt.illegal), 128'(1));
      checkOutput("ill0_imm", 128'(out_pkt.imm), 128'(0));
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("ill1_illegal", 128'(out_pkt.illegal), 128'(1));
      checkOutput("ill1_imm", 128'(out_pkt.imm), 128'(0));
      checkOutput("ill1_pc", 128'(out_pkt.pc), 128'(32'h404));
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, rand_instr(), 32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 32'hFFF0_0093, 32'h5F0, 1'b0, 1'b1, 1'b0);
      checkOutput("flush_full_valid", 128'(out_valid), 128'(0));
      applyStimulus(1'b1, rand_instr(), 32'h600, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, rand_instr(), 32'h604, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hFFF0_0093, 32'h6F0, 1'b1, 1'b1, 1'b0);
      checkOutput("flush_part_valid", 128'(out_valid), 128'(0));
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, rand_instr(), 32'h700 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 32'hFFF0_0093, 32'h7F0, 1'b0, 1'b0, 1'b1);
      checkOutput("rst_full_valid", 128'(out_valid), 128'(0));
      checkOutput("rst_full_pkt", 128'(out_pkt), 128'(0));
      applyStimulus(1'b1, 32'h0010_00EF, 32'h800, 1'b0, 1'b0, 1'b0);
      checkOutput("post_rst_pc", 128'(out_pkt.pc), 128'(32'h800));
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0),
                       1'($urandom_range(0, 60) == 0));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/rv32i_decode_queue.md
RV32I_DECODE_QUEUE -- requirements
Module: rv32i_decode_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of decoded-packet queue entries (power of two, >=2).
REQ-002 The block SHALL have parameter PC_WIDTH, default 32, meaning the width of the PC carried with each instruction.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_instr (input, 32, raw instruction word) and in_pc (input, PC_WIDTH).
REQ-006 The block SHALL have port flush, input, 1, meaning discard all queued packets.
REQ-007 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_pkt (output, decode_pkt_t).
REQ-008 decode_pkt_t SHALL contain the fields opcode, funct3, funct7, rd, rs1, rs2, imm[31:0], illegal and pc.

Function
REQ-009 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-010 in_ready SHALL be 1 iff count < DEPTH and rst=0; in_ready SHALL have no combinational dependence on out_ready (no pass-through when full).
REQ-011 The decode SHALL be combinational on in_instr, written into the entry at wr_ptr on push, and visible on out_pkt no earlier than the cycle after the push (latency 1).
REQ-012 out_valid SHALL be (count != 0); out_pkt SHALL be the head entry when valid and all-zero otherwise.
REQ-013 Pointers SHALL be $clog2(DEPTH) bits wide, increment on push/pop, and wrap from DEPTH-1 to 0; count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-014 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH-1 and count=1.
REQ-015 Immediates SHALL be formed as follows, with all formats except R sign-extended from bit 31: I = instr[31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; U = {[31:12],12'b0}; J = {[31],[19:12],[20],[30:21],0}; R = 0.
REQ-016 The instruction SHALL be marked illegal in any of these cases:
- opcode not among the 9 RV32I opcodes;
- load funct3 in {011,110,111};
- store funct3 > 010;
- branch funct3 in {010,011};
- jalr funct3 != 000;
- reg-op funct7 not in {base, variant};
- reg-op funct7 = variant with funct3 not in {add, sr};
- imm-op sll with funct7 != base;
- imm-op sr with funct7 not in {base, variant}.
REQ-017 Illegal instructions SHALL still be enqueued in order, with illegal=1 and imm=0.
REQ-018 flush SHALL set count, wr_ptr and rd_ptr to 0 at the next edge; a push or pop in the same cycle SHALL be discarded, with flush having priority.

Reset
REQ-019 While rst=1 at an edge, count, wr_ptr and rd_ptr SHALL become 0; out_valid=0 and out_pkt=0 SHALL follow.
REQ-020 in_ready SHALL be 0 while rst=1, and the queue SHALL accept a push in the first cycle after rst deasserts.
REQ-021 Reset asserted mid-operation SHALL drop all queued entries; entry storage need not be cleared.

Structure
REQ-022 decode_pkt_t, the imm-format enum (fmt_r/i/s/b/u/j) and the corrected b_type/j_type instr_t union members SHALL reside in package rv32i_types.
REQ-023 Decode SHALL be a separate combinational sub-module, rv32i_decoder (instr_t in, decode_pkt_t out, pc excluded), instantiated once.

Verification
REQ-024 Push 0xFFF00093 (addi x1,x0,-1) into an empty queue -> next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, illegal=0.
REQ-025 Push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC; push 0x001000EF (jal x1,2048) -> imm=0x00000800, rd=1.
REQ-026 With DEPTH=4 and out_ready=0, offer 5 pushes -> 4 accepted, in_ready=0 on the 5th; then pop one -> in_ready=1 the next cycle; order and pc values preserved across wrap.
REQ-027 Hold in_valid=out_ready=1 continuously at count=3 -> count stays 3 and one packet per cycle emerges in order.
REQ-028 Push 0x0000007F, then 0x40001033 -> both dequeued with illegal=1 and imm=0.
REQ-029 Assert flush while full with simultaneous in_valid=1 -> next cycle out_valid=0, count=0, and the offered instruction is never output; repeat the sequence with rst in place of flush.
